// File: rtl/snake_ctrl_fsm.sv
// Snake game sequencer: IDLE/PLAY/DIE control, periodic move step, head/direction
// registers, wall and body collision detection, score and body-length counters.
module snake_ctrl_fsm #(
    parameter int unsigned STEP_CYC  = 6_250_000,
    parameter int unsigned DIE_CYC   = 25_000_000,
    parameter int unsigned X_MAX     = 40,
    parameter int unsigned Y_MAX     = 30,
    parameter int unsigned HEAD_X0   = 20,
    parameter int unsigned HEAD_Y0   = 15,
    parameter int unsigned INIT_LEN  = 3,
    parameter int unsigned LEN_MAX   = 31,
    parameter int unsigned SCORE_MAX = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       body_hit,
    input  logic       body_add_sig,
    output logic [5:0] head_x,
    output logic [4:0] head_y,
    output logic       move_en,
    output logic [1:0] dir,
    output logic [1:0] game_state,
    output logic [9:0] score,
    output logic [4:0] body_len
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DIE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int unsigned STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int unsigned DIE_W  = (DIE_CYC > 1) ? $clog2(DIE_CYC) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [DIE_W-1:0]  DIE_LAST  = DIE_W'(DIE_CYC - 1);
    localparam logic [5:0]        X_LAST    = 6'(X_MAX - 1);
    localparam logic [4:0]        Y_LAST    = 5'(Y_MAX - 1);
    localparam logic [5:0]        X_START   = 6'(HEAD_X0);
    localparam logic [4:0]        Y_START   = 5'(HEAD_Y0);
    localparam logic [4:0]        LEN_START = 5'(INIT_LEN);
    localparam logic [4:0]        LEN_SAT   = 5'(LEN_MAX);
    localparam logic [9:0]        SCORE_SAT = 10'(SCORE_MAX);

    state_e            state_q, state_d;
    logic [5:0]        head_x_q, head_x_d;
    logic [4:0]        head_y_q, head_y_d;
    dir_e              dir_q, dir_d;
    dir_e              pend_q, pend_d;
    logic [9:0]        score_q, score_d;
    logic [4:0]        len_q, len_d;
    logic              move_en_q, move_en_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DIE_W-1:0]  die_q, die_d;

    logic       key_valid;
    dir_e       key_dir;
    dir_e       dir_rev;
    logic       step_evt;
    logic       wall;
    logic [5:0] cand_x;
    logic [4:0] cand_y;

    // Only the highest-priority key of a simultaneous group is evaluated.
    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_RIGHT;
        if (key_up) begin
            key_dir = DIR_UP;
        end else if (key_down) begin
            key_dir = DIR_DOWN;
        end else if (key_left) begin
            key_dir = DIR_LEFT;
        end else if (key_right) begin
            key_dir = DIR_RIGHT;
        end else begin
            key_valid = 1'b0;
        end
    end

    assign dir_rev  = dir_e'({dir_q[1], ~dir_q[0]});
    assign step_evt = (step_q == STEP_LAST);

    always_comb begin
        cand_x = head_x_q;
        cand_y = head_y_q;
        wall   = 1'b0;
        case (pend_q)
            DIR_UP: begin
                wall   = (head_y_q == 5'd0);
                cand_y = head_y_q - 5'd1;
            end
            DIR_DOWN: begin
                wall   = (head_y_q == Y_LAST);
                cand_y = head_y_q + 5'd1;
            end
            DIR_LEFT: begin
                wall   = (head_x_q == 6'd0);
                cand_x = head_x_q - 6'd1;
            end
            default: begin
                wall   = (head_x_q == X_LAST);
                cand_x = head_x_q + 6'd1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        score_d   = score_q;
        len_d     = len_q;
        move_en_d = 1'b0;
        step_d    = step_q;
        die_d     = die_q;

        case (state_q)
            ST_IDLE: begin
                step_d = '0;
                die_d  = '0;
                if (key_start) begin
                    state_d  = ST_PLAY;
                    head_x_d = X_START;
                    head_y_d = Y_START;
                    dir_d    = DIR_RIGHT;
                    pend_d   = DIR_RIGHT;
                    score_d  = '0;
                    len_d    = LEN_START;
                end
            end

            ST_PLAY: begin
                die_d  = '0;
                step_d = step_evt ? '0 : step_q + 1'b1;

                if (key_valid && (key_dir != dir_rev)) begin
                    pend_d = key_dir;
                end

                if (body_add_sig) begin
                    if (score_q != SCORE_SAT) score_d = score_q + 10'd1;
                    if (len_q != LEN_SAT)     len_d   = len_q + 5'd1;
                end

                // A body collision outranks a coincident step: no move is made.
                if (body_hit) begin
                    state_d = ST_DIE;
                end else if (step_evt) begin
                    if (wall) begin
                        state_d = ST_DIE;
                    end else begin
                        head_x_d  = cand_x;
                        head_y_d  = cand_y;
                        dir_d     = pend_q;
                        move_en_d = 1'b1;
                    end
                end
            end

            ST_DIE: begin
                if (die_q == DIE_LAST) begin
                    state_d = ST_IDLE;
                    die_d   = '0;
                end else begin
                    die_d = die_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            head_x_q  <= X_START;
            head_y_q  <= Y_START;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            score_q   <= '0;
            len_q     <= LEN_START;
            move_en_q <= 1'b0;
            step_q    <= '0;
            die_q     <= '0;
        end else begin
            state_q   <= state_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            score_q   <= score_d;
            len_q     <= len_d;
            move_en_q <= move_en_d;
            step_q    <= step_d;
            die_q     <= die_d;
        end
    end

    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign move_en    = move_en_q;
    assign dir        = dir_q;
    assign game_state = state_q;
    assign score      = score_q;
    assign body_len   = len_q;

endmodule

// File: tb/tb_snake_ctrl_fsm.sv
// Directed bench for snake_ctrl_fsm with a short step period (4) and die time (8).
`timescale 1ns/1ps
module tb_snake_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start, key_up, key_down, key_left, key_right;
    logic       body_hit, body_add_sig;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic       move_en;
    logic [1:0] dir;
    logic [1:0] game_state;
    logic [9:0] score;
    logic [4:0] body_len;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    snake_ctrl_fsm #(
        .STEP_CYC (4),
        .DIE_CYC  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_start    (key_start),
        .key_up       (key_up),
        .key_down     (key_down),
        .key_left     (key_left),
        .key_right    (key_right),
        .body_hit     (body_hit),
        .body_add_sig (body_add_sig),
        .head_x       (head_x),
        .head_y       (head_y),
        .move_en      (move_en),
        .dir          (dir),
        .game_state   (game_state),
        .score        (score),
        .body_len     (body_len)
    );

    // in = {start, up, down, left, right, body_hit, body_add}
    typedef struct {
        logic [6:0] in;
        int         st, x, y, mv, d, sc, len;
    } vec_t;

    vec_t vt[31];

    function automatic vec_t mk(input logic [6:0] in, input int st, input int x, input int y,
                                input int mv, input int d, input int sc, input int len);
        vec_t r;
        r.in = in; r.st = st; r.x = x; r.y = y; r.mv = mv; r.d = d; r.sc = sc; r.len = len;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int idx, input int st, input int x, input int y,
                           input int mv, input int d, input int sc, input int len);
        chk({name, ".state"}, idx, 32'(game_state), st);
        chk({name, ".x"},     idx, 32'(head_x), x);
        chk({name, ".y"},     idx, 32'(head_y), y);
        chk({name, ".move"},  idx, 32'(move_en), mv);
        chk({name, ".dir"},   idx, 32'(dir), d);
        chk({name, ".score"}, idx, 32'(score), sc);
        chk({name, ".len"},   idx, 32'(body_len), len);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] in);
        {key_start, key_up, key_down, key_left, key_right, body_hit, body_add_sig} = in;
        tick();
    endtask

    initial begin
        int moves;
        int any_mv;
        bit done;

        rst_n = 1'b0;
        {key_start, key_up, key_down, key_left, key_right, body_hit, body_add_sig} = '0;

        vt[0]  = mk(7'b1000000, 1, 20, 15, 0, 3, 0, 3);
        vt[1]  = mk(7'b0000000, 1, 20, 15, 0, 3, 0, 3);
        vt[2]  = mk(7'b0001000, 1, 20, 15, 0, 3, 0, 3);  // reverse key dropped
        vt[3]  = mk(7'b0000000, 1, 20, 15, 0, 3, 0, 3);
        vt[4]  = mk(7'b0000000, 1, 21, 15, 1, 3, 0, 3);  // first move, 4 cycles in
        vt[5]  = mk(7'b0100100, 1, 21, 15, 0, 3, 0, 3);  // up beats right
        vt[6]  = mk(7'b0000000, 1, 21, 15, 0, 3, 0, 3);
        vt[7]  = mk(7'b0000000, 1, 21, 15, 0, 3, 0, 3);
        vt[8]  = mk(7'b0000000, 1, 21, 14, 1, 0, 0, 3);
        vt[9]  = mk(7'b0000001, 1, 21, 14, 0, 0, 1, 4);
        vt[10] = mk(7'b0010000, 1, 21, 14, 0, 0, 1, 4);
        vt[11] = mk(7'b0001000, 1, 21, 14, 0, 0, 1, 4);
        vt[12] = mk(7'b0000000, 1, 20, 14, 1, 2, 1, 4);
        vt[13] = mk(7'b0010000, 1, 20, 14, 0, 2, 1, 4);
        vt[14] = mk(7'b0000100, 1, 20, 14, 0, 2, 1, 4);
        vt[15] = mk(7'b0000000, 1, 20, 14, 0, 2, 1, 4);
        vt[16] = mk(7'b0000001, 1, 20, 15, 1, 1, 2, 5);  // add on a step cycle
        vt[17] = mk(7'b0000000, 1, 20, 15, 0, 1, 2, 5);
        vt[18] = mk(7'b0000000, 1, 20, 15, 0, 1, 2, 5);
        vt[19] = mk(7'b0000000, 1, 20, 15, 0, 1, 2, 5);
        vt[20] = mk(7'b0000011, 2, 20, 15, 0, 1, 3, 6);  // hit on step cycle, add still counted
        vt[21] = mk(7'b1000001, 2, 20, 15, 0, 1, 3, 6);  // start and add ignored in DIE
        for (int i = 22; i < 28; i++) vt[i] = mk(7'b0000000, 2, 20, 15, 0, 1, 3, 6);
        vt[28] = mk(7'b0000000, 0, 20, 15, 0, 1, 3, 6);
        vt[29] = mk(7'b0100000, 0, 20, 15, 0, 1, 3, 6);
        vt[30] = mk(7'b1000000, 1, 20, 15, 0, 3, 0, 3);

        #22;
        chk_all("reset", 0, 0, 20, 15, 0, 3, 0, 3);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            drive(vt[i].in);
            chk_all("vec", i, vt[i].st, vt[i].x, vt[i].y, vt[i].mv, vt[i].d, vt[i].sc, vt[i].len);
        end

        // Right wall: 19 moves to x=39, then the next step dies without moving.
        for (int s = 1; s <= 19; s++) begin
            for (int c = 0; c < 4; c++) drive('0);
            chk("wall_mv", s, 32'(move_en), 1);
            chk("wall_x", s, 32'(head_x), 20 + s);
        end
        any_mv = 0;
        for (int c = 0; c < 4; c++) begin
            drive('0);
            if (move_en) any_mv = 1;
        end
        chk("wall_state", 0, 32'(game_state), 2);
        chk("wall_nomove", 0, any_mv, 0);
        chk("wall_hold_x", 0, 32'(head_x), 39);
        chk("wall_hold_y", 0, 32'(head_y), 15);
        for (int c = 0; c < 7; c++) drive('0);
        chk("die_len_state", 7, 32'(game_state), 2);
        drive('0);
        chk("die_len_state", 8, 32'(game_state), 0);

        // Score/length saturation, held through DIE/IDLE, cleared on start.
        drive(7'b1000000);
        for (int c = 0; c < 35; c++) drive(7'b0000001);
        chk("sat_score", 0, 32'(score), 35);
        chk("sat_len", 0, 32'(body_len), 31);
        drive(7'b0000010);
        chk("hit_state", 0, 32'(game_state), 2);
        for (int c = 0; c < 8; c++) drive('0);
        chk("idle_score", 0, 32'(score), 35);
        chk("idle_len", 0, 32'(body_len), 31);
        chk("idle_state", 0, 32'(game_state), 0);
        drive(7'b1000000);
        chk("restart_score", 0, 32'(score), 0);
        chk("restart_len", 0, 32'(body_len), 3);

        // Top wall: turn up immediately, 15 moves to y=0, then die.
        drive(7'b0100000);
        moves = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            drive('0);
            if (move_en) moves++;
            if (game_state == 2'd2) done = 1'b1;
        end
        chk("top_done", 0, 32'(done), 1);
        chk("top_moves", 0, moves, 15);
        chk("top_y", 0, 32'(head_y), 0);
        chk("top_x", 0, 32'(head_x), 20);
        chk("top_dir", 0, 32'(dir), 0);

        // Asynchronous reset mid-PLAY.
        for (int c = 0; c < 8; c++) drive('0);
        drive(7'b1000000);
        drive(7'b0000001);
        for (int c = 0; c < 5; c++) drive('0);
        chk("pre_rst_x", 0, 32'(head_x), 21);
        chk("pre_rst_score", 0, 32'(score), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 20, 15, 0, 3, 0, 3);
        tick();
        rst_n = 1'b1;
        chk_all("rst_hold", 0, 0, 20, 15, 0, 3, 0, 3);
        drive(7'b1000000);
        for (int c = 0; c < 4; c++) drive('0);
        chk("post_rst_x", 0, 32'(head_x), 21);
        chk("post_rst_mv", 0, 32'(move_en), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/snake_ctrl_fsm.md
Name: snake_ctrl_fsm

Overview:
Top-level game sequencer for the snake game. Runs the IDLE/PLAY/DIE state machine and generates the periodic move step. Owns the head coordinate (feeds the apple generator and body logic) and the direction register driven by debounced keys. Detects wall and body collisions, and counts score and body length from the apple generator's body_add_sig pulse.

Parameters:
STEP_CYC, 6_250_000, clk cycles per snake move step (250 ms at 25 MHz); legal range >= 2
DIE_CYC, 25_000_000, clk cycles spent in DIE before returning to IDLE; legal range >= 2
X_MAX, 40, grid width in cells; legal x = 0..X_MAX-1
Y_MAX, 30, grid height in cells; legal y = 0..Y_MAX-1
HEAD_X0, 20, head x loaded at reset and at game start
HEAD_Y0, 15, head y loaded at reset and at game start
INIT_LEN, 3, body length at game start
LEN_MAX, 31, body length saturation value
SCORE_MAX, 999, score saturation value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_start  in  1  one-cycle pulse, debounced start key
key_up  in  1  one-cycle pulse, debounced
key_down  in  1  one-cycle pulse, debounced
key_left  in  1  one-cycle pulse, debounced
key_right  in  1  one-cycle pulse, debounced
body_hit  in  1  level, head cell overlaps a body segment (from body logic)
body_add_sig  in  1  one-cycle pulse, apple eaten (from apple generator)
head_x  out  6  head x cell
head_y  out  5  head y cell
move_en  out  1  one-cycle pulse, asserted on the cycle the head updates
dir  out  2  committed direction: 0=up, 1=down, 2=left, 3=right
game_state  out  2  0=IDLE, 1=PLAY, 2=DIE
score  out  10  apples eaten this game
body_len  out  5  current body length in segments

Behaviour:
- Reset (async, rst_n=0) drives all outputs to these values:
  - game_state=IDLE
  - head=(HEAD_X0,HEAD_Y0)
  - dir=3 (right); pending dir=3
  - score=0, body_len=INIT_LEN, move_en=0
  - step and die counters=0
- IDLE:
  - key_start=1 -> PLAY on the next edge.
  - Same edge reloads head=(HEAD_X0,HEAD_Y0), dir=pending=3, score=0, body_len=INIT_LEN, step counter=0.
  - Direction keys are ignored. score and body_len hold their last-game values until start.
- PLAY, step counter:
  - Counts 0..STEP_CYC-1 and wraps.
  - Step event occurs when count==STEP_CYC-1.
  - First move therefore occurs STEP_CYC cycles after entering PLAY.
- PLAY, direction keys:
  - A key pulse updates the pending dir unless it is the exact reverse of the committed dir (up/down, left/right); reverse keys are dropped.
  - Simultaneous key pulses resolve by priority up>down>left>right; only the winner is evaluated.
  - The latest accepted key before a step wins.
- PLAY, step event:
  - The candidate head is the current head moved one cell in pending dir.
  - If the candidate leaves the grid (x==0 with left, x==X_MAX-1 with right, y==0 with up, y==Y_MAX-1 with down): -> DIE. Head holds, no move_en.
  - Otherwise head <= candidate, dir <= pending, and move_en=1 for exactly that cycle (registered, aligned with the new head value).
- PLAY, body_hit:
  - body_hit=1 on any cycle -> DIE next edge.
  - If it coincides with a step event, DIE wins: no move, no move_en.
- PLAY, body_add_sig:
  - score+1, saturating at SCORE_MAX.
  - body_len+1, saturating at LEN_MAX.
  - Counted even if the same cycle is a step or a collision; exactly one increment per pulse.
- key_start is ignored in PLAY and in DIE.
- DIE:
  - The die counter counts 0..DIE_CYC-1; at terminal count -> IDLE.
  - head, dir, score and body_len hold. move_en=0. All keys and body_add_sig are ignored.
- Unused game_state encoding 3 -> IDLE on the next edge.
- Reset asserted mid-game returns immediately to the reset values, regardless of state.

Test Plan:
1. STEP_CYC=4: reset, key_start pulse -> game_state=1; move_en first high 4 cycles later with head=(21,15); then every 4 cycles x increments.
2. In PLAY moving right, key_left pulse -> ignored, dir stays 3. Then key_up and key_right in the same cycle -> up wins; next step gives head y-1, dir=0.
3. Start with HEAD_X0=38 moving right: first step -> x=39; next step -> game_state=2, no move_en, head stays (39,15). After DIE_CYC=8 cycles, game_state=0.
4. body_hit asserted on the same cycle as a step event -> game_state=2 next cycle, head unchanged, move_en=0.
5. 35 body_add_sig pulses in PLAY -> score=35, body_len=31 (saturated from INIT_LEN=3). Then key_start in IDLE -> score=0, body_len=3.
6. rst_n low for 1 cycle mid-PLAY -> game_state=0, head=(20,15), score=0, dir=3 immediately; key_start pulses during DIE are ignored.
